// File: rtl/bcd2_seven_seg_mux.sv
// Two-digit BCD to multiplexed 7-segment display driver.
// Captures bcd_in once per frame at the TENS->ONES slot change so both digits
// of a frame come from the same sample, then alternates the ones and tens
// digits on a shared segment bus every REFRESH_DIV clocks.
//
// Ports:
//   clk     - system clock, rising edge
//   rst     - asynchronous reset, active low
//   bcd_in  - packed BCD, [7:4] tens, [3:0] ones
//   en      - display enable; 0 blanks the outputs, timing keeps running
//   seg     - segments a..g on seg[0]..seg[6], registered
//   an      - digit enables, an[0]=ones, an[1]=tens, registered
//   err     - registered; captured value holds a nibble greater than 9
module bcd2_seven_seg_mux #(
    parameter int unsigned REFRESH_DIV   = 1000,
    parameter bit          COMMON_ANODE  = 1'b0,
    parameter bit          BLANK_LEADING = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] bcd_in,
    input  logic       en,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       err
);

    localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned SEG_W = 7;
    localparam int unsigned AN_W  = 2;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [SEG_W-1:0] SEG_OFF  = COMMON_ANODE ? 7'h7F : 7'h00;
    localparam logic [AN_W-1:0]  AN_OFF   = COMMON_ANODE ? 2'b11 : 2'b00;

    typedef enum logic {
        SLOT_ONES = 1'b0,
        SLOT_TENS = 1'b1
    } slot_e;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    slot_e            sel_q, sel_d;
    logic [7:0]       shadow_q, shadow_d;
    logic             err_q, err_d;
    logic [SEG_W-1:0] seg_q, seg_d;
    logic [AN_W-1:0]  an_q, an_d;

    logic             tick;
    logic             frame;
    logic [3:0]       digit;
    logic [SEG_W-1:0] seg_raw;
    logic [AN_W-1:0]  an_raw;

    // Active-high segment pattern; any non-decimal nibble shows 'E'.
    function automatic logic [SEG_W-1:0] decode(input logic [3:0] d);
        logic [SEG_W-1:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h79;
        endcase
        return s;
    endfunction

    // Prescaler, slot toggle, frame capture and output formation.
    // Outputs are built from next-state sel/shadow so they move on the same
    // edge as the slot change.
    always_comb begin
        cnt_d    = cnt_q;
        sel_d    = sel_q;
        shadow_d = shadow_q;
        err_d    = err_q;
        digit    = 4'h0;
        seg_raw  = 7'h00;
        an_raw   = 2'b00;
        seg_d    = SEG_OFF;
        an_d     = AN_OFF;

        tick  = (cnt_q == CNT_LAST);
        frame = tick && (sel_q == SLOT_TENS);

        cnt_d = tick ? '0 : CNT_W'(cnt_q + CNT_W'(1));

        if (tick) begin
            sel_d = (sel_q == SLOT_ONES) ? SLOT_TENS : SLOT_ONES;
        end

        if (frame) begin
            shadow_d = bcd_in;
            err_d    = (bcd_in[7:4] > 4'd9) || (bcd_in[3:0] > 4'd9);
        end

        if (sel_d == SLOT_TENS) begin
            digit  = shadow_d[7:4];
            an_raw = 2'b10;
        end else begin
            digit  = shadow_d[3:0];
            an_raw = 2'b01;
        end
        seg_raw = decode(digit);

        // Leading-zero blanking applies to the tens slot only.
        if (BLANK_LEADING && (sel_d == SLOT_TENS) && (digit == 4'h0)) begin
            seg_raw = 7'h00;
            an_raw  = 2'b00;
        end

        if (!en) begin
            seg_raw = 7'h00;
            an_raw  = 2'b00;
        end

        seg_d = COMMON_ANODE ? ~seg_raw : seg_raw;
        an_d  = COMMON_ANODE ? ~an_raw  : an_raw;
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q    <= '0;
            sel_q    <= SLOT_ONES;
            shadow_q <= 8'h00;
            err_q    <= 1'b0;
            seg_q    <= SEG_OFF;
            an_q     <= AN_OFF;
        end else begin
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
            shadow_q <= shadow_d;
            err_q    <= err_d;
            seg_q    <= seg_d;
            an_q     <= an_d;
        end
    end

    assign seg = seg_q;
    assign an  = an_q;
    assign err = err_q;

endmodule
